ysyx_22040750_mul_ctrl: RTL and testbench

Issue and collect controller between the EX stage and the serial radix-4 Booth multiplier. It decodes RV64M multiply ops into multiplier operands and the per-operand sign-extension flags. It launches one multiply at a time, captures the 128-bit product on the multiplier's completion pulse and selects the 64-bit result. It then holds that result behind a valid/ready handshake toward the MEM stage.

---
 rtl/ysyx_22040750_mul_ctrl.sv | 174 +++++++++++++++++
 tb/tb_ysyx_22040750_mul_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040750_mul_ctrl.sv
// ============================================================================
// ysyx_22040750_mul_ctrl
// ----------------------------------------------------------------------------
// Issue/collect controller between the EX stage and the serial radix-4 Booth
// multiplier. Decodes RV64M multiply ops into multiplier operands and the
// per-operand sign-extension flags. It launches one multiply at a time and
// captures the 128-bit product on the completion pulse. It then holds the
// selected 64-bit result behind a valid/ready handshake toward MEM.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   in_valid/in_ready   EX-side handshake (in_ready combinational)
//   op, src1, src2      op code (101-111 behave as MUL) and rs1/rs2 values
//   flush               pipeline kill for the in-flight or held op
//   mul1, mul2          multiplier operands (combinational from inputs)
//   sext_flag           [1] sign-extend mul1, [0] sign-extend mul2
//   mul_valid           one-cycle launch strobe (combinational)
//   P_valid, P          multiplier completion pulse and 128-bit product
//   out_valid/out_ready MEM-side handshake (out_valid registered)
//   result              selected 64-bit result (registered)
//
// Configuration macro:
//   YSYX_22040750_MUL_ZERO_BYPASS_EN - a zero operand skips the multiplier.
//   The result is 0 and it is presented the cycle after accept.
// ============================================================================
module ysyx_22040750_mul_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [63:0]  src1,
    input  logic [63:0]  src2,
    input  logic         flush,
    output logic [63:0]  mul1,
    output logic [63:0]  mul2,
    output logic [1:0]   sext_flag,
    output logic         mul_valid,
    input  logic         P_valid,
    input  logic [127:0] P,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  result
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_MULW   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DONE  = 2'b10,
        ST_DRAIN = 2'b11
    } state_e;

    state_e      state_r;
    logic [2:0]  op_sel_r;
    logic [63:0] result_r;
    logic        out_valid_r;

    logic [2:0]  op_n_s;
    logic        accept_s;
    logic        zero_s;

    // Fold the reserved encodings onto MUL so decode and select see five ops.
    function automatic logic [2:0] norm_op(input logic [2:0] o);
        case (o)
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW: return o;
            default:                                      return OP_MUL;
        endcase
    endfunction

    // Pick the architectural 64-bit result out of the 128-bit product.
    function automatic logic [63:0] sel_result(input logic [2:0] o, input logic [127:0] p);
        case (norm_op(o))
            OP_MULH, OP_MULHSU, OP_MULHU: return p[127:64];
            OP_MULW:                      return {{32{p[31]}}, p[31:0]};
            default:                      return p[63:0];
        endcase
    endfunction

    assign op_n_s    = norm_op(op);
    assign in_ready  = (state_r == ST_IDLE) & ~flush;
    assign accept_s  = in_valid & in_ready;
    assign mul_valid = accept_s & ~zero_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;

    // Operand and sign-extension decode; MULW zero-extends so the multiplier
    // terminates early on the short operands.
    always_comb begin
        mul1      = src1;
        mul2      = src2;
        sext_flag = 2'b00;
        case (op_n_s)
            OP_MULH:   sext_flag = 2'b11;
            OP_MULHSU: sext_flag = 2'b10;
            OP_MULHU:  sext_flag = 2'b00;
            OP_MULW: begin
                mul1 = {32'h0000_0000, src1[31:0]};
                mul2 = {32'h0000_0000, src2[31:0]};
            end
            default:   sext_flag = 2'b00;
        endcase
    end

    // Zero-operand detection for the multiplier bypass (inactive by default).
    always_comb begin
`ifdef YSYX_22040750_MUL_ZERO_BYPASS_EN
        if (op_n_s == OP_MULW) begin
            zero_s = (src1[31:0] == 32'h0000_0000) | (src2[31:0] == 32'h0000_0000);
        end else begin
            zero_s = (src1 == 64'h0) | (src2 == 64'h0);
        end
`else
        zero_s = 1'b0;
`endif
    end

    // Control FSM with registered result and out_valid. Flush wins over
    // P_valid and out_ready. DRAIN absorbs the product of a killed op
    // because the multiplier cannot be aborted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            op_sel_r    <= 3'b000;
            result_r    <= 64'h0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_sel_r <= op;
                        if (zero_s) begin
                            result_r    <= 64'h0;
                            out_valid_r <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            state_r <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        state_r <= ST_DRAIN;
                    end else if (P_valid) begin
                        result_r    <= sel_result(op_sel_r, P);
                        out_valid_r <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (flush || out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (P_valid) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040750_mul_ctrl.sv
// Self-checking bench for ysyx_22040750_mul_ctrl. It includes a behavioural
// multiplier that answers each launch after a chosen latency k. Expected
// results come from plain RV64M arithmetic on the original op and operands.
module tb_ysyx_22040750_mul_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [63:0]  src1, src2;
    logic         flush;
    logic [63:0]  mul1, mul2;
    logic [1:0]   sext_flag;
    logic         mul_valid;
    logic         P_valid;
    logic [127:0] P;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  result;

    logic         pv_m, pv_spur;
    logic [127:0] p_m;
    int           k_next;
    logic         busy_m;
    int           cnt_m;
    logic [127:0] prod_m;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [63:0]  last_res;

    always #5 clk = ~clk;

    assign P_valid = pv_m | pv_spur;
    assign P       = pv_spur ? 128'hDEAD_BEEF_0BAD_F00D_1357_9BDF_2468_ACE0 : p_m;

    ysyx_22040750_mul_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src1(src1), .src2(src2), .flush(flush), .mul1(mul1), .mul2(mul2),
        .sext_flag(sext_flag), .mul_valid(mul_valid), .P_valid(P_valid), .P(P),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    function automatic logic [127:0] ext(input logic [63:0] v, input logic s);
        return s ? {{64{v[63]}}, v} : {64'd0, v};
    endfunction

    // Behavioural multiplier: P_valid arrives k cycles after the first
    // iteration cycle. P carries junk whenever P_valid is low.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_m <= 1'b0; pv_m <= 1'b0; cnt_m <= 0; prod_m <= '0; p_m <= '0;
        end else begin
            pv_m <= 1'b0;
            p_m  <= {$urandom, $urandom, $urandom, $urandom};
            if (mul_valid) begin
                busy_m <= 1'b1;
                cnt_m  <= k_next - 1;
                prod_m <= ext(mul1, sext_flag[1]) * ext(mul2, sext_flag[0]);
            end else if (busy_m) begin
                if (cnt_m == 0) begin
                    pv_m <= 1'b1; p_m <= prod_m; busy_m <= 1'b0;
                end else begin
                    cnt_m <= cnt_m - 1;
                end
            end
        end
    end

    // Architectural RV64M result computed with signed/unsigned arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa, sb;
        logic [127:0] ua, ub, w;
        logic [63:0]  lo;
        sa = $signed(a); sb = $signed(b);
        ua = {64'd0, a}; ub = {64'd0, b};
        case (o)
            3'd1: begin w = sa * sb; return w[127:64]; end
            3'd2: begin w = sa * ub; return w[127:64]; end
            3'd3: begin w = ua * ub; return w[127:64]; end
            3'd4: begin lo = {32'd0, a[31:0]} * {32'd0, b[31:0]}; return {{32{lo[31]}}, lo[31:0]}; end
            default: begin lo = a * b; return lo; end
        endcase
    endfunction

    function automatic logic [1:0] ref_flags(input logic [2:0] o);
        return (o == 3'd1) ? 2'b11 : (o == 3'd2) ? 2'b10 : 2'b00;
    endfunction

    function automatic logic [63:0] ref_opnd(input logic [2:0] o, input logic [63:0] a);
        return (o == 3'd4) ? {32'd0, a[31:0]} : a;
    endfunction

    function automatic logic ref_bypass(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
`ifdef YSYX_22040750_MUL_ZERO_BYPASS_EN
        if (o == 3'd4) return (a[31:0] == 32'd0) || (b[31:0] == 32'd0);
        return (a == 64'd0) || (b == 64'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic launch(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b, input int k);
        k_next = k; in_valid = 1'b1; op = o; src1 = a; src2 = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 60) begin tick(); n++; end
    endtask

    // One full op: operand/strobe checks, latency, hold while stalled, handshake.
    task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] er, input int rd);
        logic byp, ok;
        int   k, n;
        byp = ref_bypass(o, a, b);
        k = $urandom_range(1, 6);
        k_next = k; in_valid = 1'b1; op = o; src1 = a; src2 = b;
        #1;
        chk("in_ready_idle", 128'(in_ready), 128'(1'b1));
        chk("mul_valid", 128'(mul_valid), 128'(!byp));
        chk("mul1", 128'(mul1), 128'(ref_opnd(o, a)));
        chk("mul2", 128'(mul2), 128'(ref_opnd(o, b)));
        chk("sext_flag", 128'(sext_flag), 128'(ref_flags(o)));
        tick();
        in_valid = 1'b0; op = 3'($urandom); src1 = {$urandom, $urandom}; src2 = {$urandom, $urandom};
        n = 0; ok = 1'b1;
        while (!out_valid && n < 60) begin
            if (in_ready !== 1'b0 || mul_valid !== 1'b0) ok = 1'b0;
            tick(); n++;
        end
        chk("busy_in_ready_low", 128'(ok), 128'(1'b1));
        chk("out_valid_latency", 128'(n), byp ? 128'(0) : 128'(k + 1));
        chk("result", 128'(result), 128'(er));
        ok = 1'b1;
        repeat (rd) begin
            tick();
            if (out_valid !== 1'b1 || result !== er || in_ready !== 1'b0) ok = 1'b0;
        end
        chk("hold_stable", 128'(ok), 128'(1'b1));
        out_ready = 1'b1; in_valid = 1'b1; #1;
        chk("no_accept_in_handshake", 128'({in_ready, mul_valid}), 128'(2'b00));
        tick();
        out_ready = 1'b0; in_valid = 1'b0; #1;
        chk("out_valid_drop", 128'(out_valid), 128'(1'b0));
        chk("idle_after_handshake", 128'(in_ready), 128'(1'b1));
        last_res = er;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_res;
        logic [1:0]  exp_flags;
        int          rd;
    } vec_t;

    vec_t vecs[8];
    int   n;

    initial begin
        vecs[0] = '{3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2'b11, 0};
        vecs[1] = '{3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1};
        vecs[2] = '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h1, 2'b00, 0};
        vecs[3] = '{3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 2};
        vecs[4] = '{3'd4, 64'h1234_5678_7FFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00, 0};
        vecs[5] = '{3'd0, 64'h3, 64'h5, 64'd15, 2'b00, 5};
        vecs[6] = '{3'd1, 64'h8000_0000_0000_0000, 64'h2, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 0};
        vecs[7] = '{3'd7, 64'h7, 64'h6, 64'd42, 2'b00, 1};

        rst = 1'b0; in_valid = 1'b0; op = 3'd0; src1 = 64'd0; src2 = 64'd0;
        flush = 1'b0; out_ready = 1'b0; pv_spur = 1'b0; k_next = 1; last_res = 64'd0;
        tick(); tick();
        chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
        chk("reset_out_valid", 128'(out_valid), 128'(1'b0));
        chk("reset_result", 128'(result), 128'(64'd0));
        chk("reset_mul_valid", 128'(mul_valid), 128'(1'b0));
        rst = 1'b1;
        tick();

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            chk("table_flags_decode", 128'(ref_flags(vecs[i].op)), 128'(vecs[i].exp_flags));
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].rd);
        end

        // Zero operand: bypassed when the option is built in, normal path otherwise.
        run_op(3'd0, 64'd0, 64'd7, 64'd0, 1);

        // Flush two cycles after accept: drain the product, nothing delivered.
        launch(3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 10);
        tick();
        flush = 1'b1; #1;
        chk("flush_busy_in_ready", 128'(in_ready), 128'(1'b0));
        tick();
        flush = 1'b0;
        begin
            logic ok;
            ok = 1'b1; n = 0;
            while (!P_valid && n < 40) begin
                if (out_valid !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
                tick(); n++;
            end
            chk("drain_quiet", 128'(ok), 128'(1'b1));
            chk("drain_pvalid_seen", 128'(n < 40), 128'(1'b1));
        end
        chk("drain_in_ready_on_pvalid", 128'(in_ready), 128'(1'b0));
        tick();
        chk("drain_exit_in_ready", 128'(in_ready), 128'(1'b1));
        chk("drain_no_out_valid", 128'(out_valid), 128'(1'b0));
        chk("drain_result_kept", 128'(result), 128'(last_res));
        run_op(3'd0, 64'd2, 64'd3, 64'd6, 0);

        // Flush while idle: no accept.
        in_valid = 1'b1; flush = 1'b1; op = 3'd0; src1 = 64'd9; src2 = 64'd9; #1;
        chk("flush_idle_no_accept", 128'({in_ready, mul_valid}), 128'(2'b00));
        tick();
        in_valid = 1'b0; flush = 1'b0; #1;
        chk("flush_idle_stays_idle", 128'({in_ready, out_valid}), 128'(2'b10));

        // Spurious P_valid in DONE is ignored; flush in DONE drops the result.
        launch(3'd0, 64'd5, 64'd7, 3);
        wait_out(n);
        chk("done_result", 128'(result), 128'(64'd35));
        pv_spur = 1'b1;
        tick();
        pv_spur = 1'b0;
        chk("done_spur_ignored", 128'({out_valid, result}), 128'({1'b1, 64'd35}));
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0; #1;
        chk("flush_done_to_idle", 128'({in_ready, out_valid}), 128'(2'b10));

        // Spurious P_valid in IDLE is ignored.
        pv_spur = 1'b1;
        tick();
        pv_spur = 1'b0; #1;
        chk("idle_spur_ignored", 128'({in_ready, out_valid}), 128'(2'b10));

        // Randomised ops against the arithmetic reference.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [63:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            rb = ($urandom_range(0, 7) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            run_op(ro, ra, rb, ref_result(ro, ra, rb), $urandom_range(0, 3));
        end

        // Asynchronous reset in the middle of BUSY.
        run_op(3'd0, 64'd2, 64'd3, 64'd6, 0);
        launch(3'd0, 64'd4, 64'd4, 20);
        @(posedge clk); #2;
        rst = 1'b0; #1;
        chk("async_rst_in_ready", 128'(in_ready), 128'(1'b1));
        chk("async_rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("async_rst_result", 128'(result), 128'(64'd0));
        @(negedge clk);
        rst = 1'b1;
        tick();
        run_op(3'd4, 64'hFFFF_FFFF_8000_0000, 64'd3, ref_result(3'd4, 64'hFFFF_FFFF_8000_0000, 64'd3), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
